// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 8-digit common-anode 7-seg scanner (clk, rst, data_in/digit_en_in/load in; anode/sseg active-low, frame_start, pending out) with shared gm_led_7doan hex decoder
module gm_led_7doan (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  digit_en_in,
  input  logic        load,
  output logic [7:0]  anode,
  output logic [6:0]  sseg,
  output logic        frame_start,
  output logic        pending
);
  localparam int TW = $clog2(DIGIT_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(DIGIT_TICKS - 1);
  localparam logic [TW-1:0] TBLANK = TW'(BLANK_TICKS);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t state, state_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [2:0] idx, idx_nxt;
  logic [31:0] act_data, pend_data;
  logic [7:0] act_en, pend_en, anode_nxt;
  logic [6:0] dec_seg, sseg_nxt;
  logic wrap, boundary, lit;
  gm_led_7doan u_dec (.hex(act_data[{idx, 2'b00} +: 4]), .seg(dec_seg));
  always_comb begin
    wrap = tick == TLAST;
    boundary = wrap && idx == 3'd0;
    tick_nxt = wrap ? '0 : tick + TW'(1);
    idx_nxt = wrap ? idx - 3'd1 : idx;
    state_nxt = tick_nxt < TBLANK ? BLANK : SHOW;
    lit = state == SHOW && act_en[idx];
    anode_nxt = lit ? ~(8'b1 << idx) : 8'hFF;
    sseg_nxt = lit ? dec_seg : 7'h7F;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      tick <= '0;
      idx <= 3'd7;
      anode <= 8'hFF;
      sseg <= 7'h7F;
      frame_start <= 1'b0;
      pending <= 1'b0;
      pend_data <= '0;
      pend_en <= '0;
      act_data <= '0;
      act_en <= 8'hFF;
    end else begin
      state <= state_nxt;
      tick <= tick_nxt;
      idx <= idx_nxt;
      anode <= anode_nxt;
      sseg <= sseg_nxt;
      frame_start <= tick == '0 && idx == 3'd7;
      pending <= load | (pending & ~boundary);
      if (load) begin
        pend_data <= data_in;
        pend_en <= digit_en_in;
      end
      if (boundary && pending) begin
        act_data <= pend_data;
        act_en <= pend_en;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized bench against a cycle-count reference model of the scan controller
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0] digit_en_in = '0;
  logic [7:0] anode;
  logic [6:0] sseg;
  logic frame_start, pending;
  int checks = 0, errors = 0;
  int n = 0;
  logic [31:0] ad, pd;
  logic [7:0] ae, pe, ea;
  logic [6:0] es;
  logic pf, efs;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg7_scan_ctrl #(.DIGIT_TICKS(8), .BLANK_TICKS(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .digit_en_in(digit_en_in), .load(load),
    .anode(anode), .sseg(sseg), .frame_start(frame_start), .pending(pending)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t, n=%0d)", tag, got, exp, $time, n);
    end
  endtask
  task automatic cycle();
    int p, tk, ix;
    logic show;
    @(posedge clk);
    if (rst) begin
      n = 0; ad = '0; ae = 8'hFF; pd = '0; pe = '0; pf = 1'b0;
      ea = 8'hFF; es = 7'h7F; efs = 1'b0;
    end else begin
      p = n % 64; tk = p % 8; ix = 7 - p / 8;
      show = tk >= 2 && ae[ix];
      ea = show ? ~(8'd1 << ix) : 8'hFF;
      es = show ? SEG[(ad >> (4 * ix)) & 32'hF] : 7'h7F;
      efs = p == 0;
      if (p == 63 && pf) begin
        ad = pd;
        ae = pe;
      end
      pf = load || (pf && p != 63);
      if (load) begin
        pd = data_in;
        pe = digit_en_in;
      end
      n++;
    end
    #1;
    check("anode", anode, ea);
    check("sseg", sseg, es);
    check("frame_start", frame_start, efs);
    check("pending", pending, pf);
    load = 1'b0;
  endtask
  task automatic run(int k);
    repeat (k) cycle();
  endtask
  task automatic run_to(int pos);
    while (n % 64 != pos) cycle();
  endtask
  task automatic do_load(logic [31:0] d, logic [7:0] e);
    data_in = d;
    digit_en_in = e;
    load = 1'b1;
    cycle();
  endtask
  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(70);
    do_load(32'h8765_4321, 8'hFF);
    run(140);
    run_to(36);
    do_load(32'hAAAA_AAAA, 8'hFF);
    run(100);
    do_load(32'h1234_5678, 8'hF0);
    run(140);
    run_to(20);
    do_load(32'h0F0F_0F0F, 8'hFF);
    run_to(63);
    do_load(32'hCDEF_9876, 8'h5A);
    run(140);
    run_to(30);
    do_load(32'h1111_2222, 8'hFF);
    run_to(44);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(80);
    run_to(10);
    data_in = 32'hBBBB_BBBB;
    digit_en_in = 8'hFF;
    load = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(70);
    repeat (1500) begin
      if ($urandom_range(0, 99) < 4) begin
        data_in = $urandom;
        digit_en_in = $urandom_range(0, 1) ? 8'hFF : 8'($urandom);
        load = 1'b1;
      end
      rst = $urandom_range(0, 499) == 0;
      cycle();
      rst = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
